// File: rtl/rx_fifo_ctrl.sv
// Receive-buffer controller: circular FIFO of received words plus their framing bit,
// popped by APB data reads, with sticky overrun / framing-error status for software.
module rx_fifo_ctrl #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load_buffer,
    input  logic [DATA_W-1:0]            rx_data,
    input  logic                         rx_framing_error,
    input  logic                         read_req,
    input  logic                         clear_errors,
    output logic [DATA_W-1:0]            rd_data,
    output logic                         rd_ferr,
    output logic                         data_ready,
    output logic                         fifo_full,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overrun_error,
    output logic                         framing_error_flag
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [DATA_W:0]    mem_q [DEPTH];
    logic [DATA_W:0]    wr_entry_d;
    logic [DATA_W:0]    head;

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovr_q, ovr_d;
    logic               ferr_flag_q, ferr_flag_d;

    logic               empty;
    logic               full;
    logic               push_ok;
    logic               pop_ok;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_FULL);

    always_comb begin
        pop_ok      = read_req && !empty;
        // A full FIFO still takes a push when a pop frees the head slot in the same cycle.
        push_ok     = load_buffer && (!full || pop_ok);
        wr_entry_d  = {rx_framing_error, rx_data};

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // Set wins over a simultaneous clear.
        ovr_d       = (load_buffer && !push_ok) || (ovr_q && !clear_errors);
        ferr_flag_d = (push_ok && rx_framing_error) || (ferr_flag_q && !clear_errors);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovr_q       <= 1'b0;
            ferr_flag_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ovr_q       <= ovr_d;
            ferr_flag_q <= ferr_flag_d;
        end
    end

    // Storage is deliberately left unreset; count and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_entry_d;
        end
    end

    assign head = mem_q[rd_ptr_q];

    always_comb begin
        rd_data = '0;
        rd_ferr = 1'b0;
        if (!empty) begin
            rd_data = head[DATA_W-1:0];
            rd_ferr = head[DATA_W];
        end
    end

    assign data_ready         = !empty;
    assign fifo_full          = full;
    assign count              = count_q;
    assign overrun_error      = ovr_q;
    assign framing_error_flag = ferr_flag_q;

endmodule

// File: tb/tb_rx_fifo_ctrl.sv
// Self-checking bench for rx_fifo_ctrl: directed vector table, wrap and async-reset
// sequences, then random traffic against a queue-based reference model.
module tb_rx_fifo_ctrl;

    localparam int DEPTH  = 8;
    localparam int DATA_W = 8;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk;
    logic              rst;
    logic              load_buffer;
    logic [DATA_W-1:0] rx_data;
    logic              rx_framing_error;
    logic              read_req;
    logic              clear_errors;
    logic [DATA_W-1:0] rd_data;
    logic              rd_ferr;
    logic              data_ready;
    logic              fifo_full;
    logic [CNT_W-1:0]  count;
    logic              overrun_error;
    logic              framing_error_flag;

    int errors = 0;
    int checks = 0;

    rx_fifo_ctrl #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk                (clk),
        .rst                (rst),
        .load_buffer        (load_buffer),
        .rx_data            (rx_data),
        .rx_framing_error   (rx_framing_error),
        .read_req           (read_req),
        .clear_errors       (clear_errors),
        .rd_data            (rd_data),
        .rd_ferr            (rd_ferr),
        .data_ready         (data_ready),
        .fifo_full          (fifo_full),
        .count              (count),
        .overrun_error      (overrun_error),
        .framing_error_flag (framing_error_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       ld;
        logic [7:0] d;
        logic       fe;
        logic       rd;
        logic       clr;
        logic [3:0] e_cnt;
        logic [7:0] e_data;
        logic       e_ferr;
        logic       e_ovr;
        logic       e_fe;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input int ld, input int d, input int fe, input int rd,
                                input int clr, input int e_cnt, input int e_data,
                                input int e_ferr, input int e_ovr, input int e_fe);
        vec_t v;
        v.ld = ld[0]; v.d = d[7:0]; v.fe = fe[0]; v.rd = rd[0]; v.clr = clr[0];
        v.e_cnt = e_cnt[3:0]; v.e_data = e_data[7:0]; v.e_ferr = e_ferr[0];
        v.e_ovr = e_ovr[0]; v.e_fe = e_fe[0];
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic step(input logic ld, input logic [7:0] d, input logic fe,
                        input logic rd, input logic clr);
        load_buffer      = ld;
        rx_data          = d;
        rx_framing_error = fe;
        read_req         = rd;
        clear_errors     = clr;
        @(posedge clk);
        #1;
        load_buffer      = 1'b0;
        rx_data          = '0;
        rx_framing_error = 1'b0;
        read_req         = 1'b0;
        clear_errors     = 1'b0;
    endtask

    task automatic chk_all(input string tag, input int idx, input int e_cnt, input int e_data,
                           input int e_ferr, input int e_ovr, input int e_fe);
        chk({tag, ".count"},   idx, 32'(count),              32'(e_cnt));
        chk({tag, ".rd_data"}, idx, 32'(rd_data),            32'(e_data));
        chk({tag, ".rd_ferr"}, idx, 32'(rd_ferr),            32'(e_ferr));
        chk({tag, ".ready"},   idx, 32'(data_ready),         32'(e_cnt != 0));
        chk({tag, ".full"},    idx, 32'(fifo_full),          32'(e_cnt == DEPTH));
        chk({tag, ".ovr"},     idx, 32'(overrun_error),      32'(e_ovr));
        chk({tag, ".fe"},      idx, 32'(framing_error_flag), 32'(e_fe));
    endtask

    logic [8:0] model_q[$];
    logic       m_ovr;
    logic       m_fe;

    initial begin
        rst = 1'b1;
        load_buffer = 1'b0; rx_data = '0; rx_framing_error = 1'b0;
        read_req = 1'b0; clear_errors = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        // directed table: ld d fe rd clr | cnt data ferr ovr fe
        add(1, 8'hA5, 0, 0, 0, 1, 8'hA5, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) add(1, i + 1, 0, 0, 0, i + 1, 8'h01, 0, 0, 0);
        add(1, 8'h09, 0, 0, 0, 8, 8'h01, 0, 1, 0);
        for (int i = 0; i < 8; i++) add(0, 0, 0, 1, 0, 7 - i, (i < 7) ? i + 2 : 0, 0, 1, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) add(1, 8'h11 + i, 0, 0, 0, i + 1, 8'h11, 0, 0, 0);
        add(1, 8'h55, 0, 1, 0, 8, 8'h12, 0, 0, 0);
        for (int k = 1; k <= 8; k++)
            add(0, 0, 0, 1, 0, 8 - k, (k == 8) ? 0 : ((k < 7) ? 8'h12 + k : 8'h55), 0, 0, 0);
        add(1, 8'h3C, 0, 1, 0, 1, 8'h3C, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 8'h7E, 1, 0, 0, 1, 8'h7E, 1, 0, 1);
        add(0, 0, 0, 0, 1, 1, 8'h7E, 1, 0, 0);
        add(1, 8'h01, 1, 0, 1, 2, 8'h7E, 1, 0, 1);
        add(0, 0, 0, 1, 0, 1, 8'h01, 1, 0, 1);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) add(1, 8'h20 + i, 0, 0, 0, i + 1, 8'h20, 0, 0, 0);
        add(1, 8'h99, 1, 0, 0, 8, 8'h20, 0, 1, 0);
        add(1, 8'h9A, 0, 0, 1, 8, 8'h20, 0, 1, 0);
        for (int k = 1; k <= 8; k++) add(0, 0, 0, 1, 0, 8 - k, (k < 8) ? 8'h20 + k : 0, 0, 1, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].ld, vecs[i].d, vecs[i].fe, vecs[i].rd, vecs[i].clr);
            chk_all("vec", i, vecs[i].e_cnt, vecs[i].e_data, vecs[i].e_ferr,
                    vecs[i].e_ovr, vecs[i].e_fe);
        end

        // wrap-around: 20 push/pop pairs walk both pointers around the ring
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
            chk_all("wrap_push", i, 1, 8'h10 + i, 0, 0, 0);
            step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
            chk_all("wrap_pop", i, 0, 0, 0, 0, 0);
        end

        // random traffic against a queue model
        model_q.delete();
        m_ovr = 1'b0;
        m_fe  = 1'b0;
        for (int n = 0; n < 400; n++) begin
            logic       r_ld, r_fe, r_rd, r_clr, push_ok, pop_ok;
            logic [7:0] r_d;
            r_ld  = ($urandom_range(0, 99) < 55);
            r_rd  = ($urandom_range(0, 99) < 40);
            r_clr = ($urandom_range(0, 99) < 10);
            r_fe  = ($urandom_range(0, 99) < 25);
            r_d   = 8'($urandom);
            pop_ok  = r_rd && (model_q.size() > 0);
            push_ok = r_ld && (model_q.size() < DEPTH || pop_ok);
            if (pop_ok) void'(model_q.pop_front());
            if (push_ok) model_q.push_back({r_fe, r_d});
            m_ovr = (r_ld && !push_ok) || (m_ovr && !r_clr);
            m_fe  = (push_ok && r_fe) || (m_fe && !r_clr);
            step(r_ld, r_d, r_fe, r_rd, r_clr);
            if (model_q.size() > 0)
                chk_all("rand", n, model_q.size(), model_q[0][7:0], model_q[0][8], m_ovr, m_fe);
            else
                chk_all("rand", n, 0, 0, 0, m_ovr, m_fe);
        end

        // asynchronous reset mid-stream with three entries stored
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        while (count != 0) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
        chk_all("pre_rst", 0, 3, 8'hC0, 0, 0, 0);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst.count", 0, 32'(count), 32'd0);
        chk("async_rst.ready", 0, 32'(data_ready), 32'd0);
        chk("async_rst.rd_data", 0, 32'(rd_data), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        chk_all("post_rst", 0, 1, 8'h5A, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
